vga_timing_gen: RTL
===================

# vga_timing_gen

- Generates the VGA raster timing consumed by the drawing pipeline.
- Free-running horizontal/vertical counters on `vga_pix_clk` produce the pixel coordinates `sx`/`sy`, `display_enabled`, the `hsync`/`vsync` pulses, and a once-per-frame `frame_stb`.
- Sits between the pixel clock source and `drawing_logic`; its outputs feed that block's `sx`, `sy`, `display_enabled` and `frame_stb` inputs directly, with the sync pins routed to the board.
- All outputs are registered and mutually aligned to the same pixel.

## Interface
Parameters:
- H_VISIBLE_AREA, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_VISIBLE_AREA, 480, visible lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync
- FRAME_CNT_WIDTH, 16, width of frame_cnt
- localparams H_WHOLE_LINE / V_WHOLE_LINE (sum of the four), H_ADDR_WIDTH = $clog2(H_WHOLE_LINE), V_ADDR_WIDTH = $clog2(V_WHOLE_LINE)

Ports:
- vga_pix_clk  in  1  pixel clock, sole clock
- rst  in  1  reset, asynchronous, active-low
- sx  out  H_ADDR_WIDTH  current pixel column, 0..H_WHOLE_LINE-1
- sy  out  V_ADDR_WIDTH  current line, 0..V_WHOLE_LINE-1
- display_enabled  out  1  high when sx < H_VISIBLE_AREA and sy < V_VISIBLE_AREA
- hsync  out  1  horizontal sync, level per H_SYNC_POL
- vsync  out  1  vertical sync, level per V_SYNC_POL
- frame_stb  out  1  one-cycle pulse at the start of vertical blanking
- frame_cnt  out  FRAME_CNT_WIDTH  completed-frame count (see Configuration)

## Operation
- `sx` increments every `vga_pix_clk` cycle.
  - At H_WHOLE_LINE-1, `sx` wraps to 0 and `sy` increments.
  - At `sy` = V_WHOLE_LINE-1 with `sx` = H_WHOLE_LINE-1, both wrap to 0.
- Decoded outputs are registered from the next-state counter values, so they describe the same pixel as `sx`/`sy` in the same cycle. The decodes are:
  - display_enabled = (sx < H_VISIBLE_AREA) && (sy < V_VISIBLE_AREA)
  - hsync active when H_VISIBLE_AREA+H_FRONT_PORCH ≤ sx < H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE
  - vsync active when V_VISIBLE_AREA+V_FRONT_PORCH ≤ sy < V_VISIBLE_AREA+V_FRONT_PORCH+V_SYNC_PULSE
    - vsync is line-granular; it changes with the `sx` wrap.
  - frame_stb = (sx == 0) && (sy == V_VISIBLE_AREA)
    - Exactly one cycle per frame.
    - Game logic uses it to update state during blanking.
- All comparisons are unsigned and use counter width. Each parameter sum must fit its address width; no saturation logic exists.
- There is no enable or stall input. Timing never pauses.

## Timing
- Reset (rst low, asynchronous) forces these values:
  - sx = 0, sy = 0
  - display_enabled = 0, frame_stb = 0
  - hsync = !H_SYNC_POL, vsync = !V_SYNC_POL
  - frame_cnt = 0
- First rising edge after rst deasserts gives sx = 1, sy = 0, display_enabled = 1.
  - Pixel (0,0) of the first frame after reset is therefore blanked. This is intentional.
- Decode-to-counter latency is 0 cycles; all outputs change on the same edge.
- Line period is H_WHOLE_LINE cycles. Frame period is H_WHOLE_LINE × V_WHOLE_LINE cycles (420 000 at defaults).
- Reset mid-frame aborts immediately. The frame restarts from (0,0) with no frame_stb for the aborted frame.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - frame_cnt increments by 1 on the same edge that frame_stb asserts.
  - Wraps modulo 2^FRAME_CNT_WIDTH.
  - Used for animation and blink timing.
- Not defined:
  - frame_cnt is tied to 0 and no counter register is synthesized.
  - The port remains present.

## Test plan
- Reset release at defaults -> sx=0, sy=0, display_enabled=0, hsync=vsync=1 during reset; one edge later sx=1, display_enabled=1.
- Run one line -> hsync low exactly for sx 656..751 (96 cycles); display_enabled falls at sx=640; sx wraps 799->0 with sy 0->1.
- Run full frame -> vsync low exactly for sy 490..491 (1600 cycles); sy wraps 524->0 at sx 799->0.
- Run three frames -> frame_stb high exactly once per 420 000 cycles, at sx=0/sy=480; frame_cnt 0->1->2->3 with macro defined, constant 0 without.
- Assert rst at sx=300, sy=200 -> outputs reset asynchronously before the next edge; no frame_stb until sy=480 of the restarted frame.
- Override H_SYNC_POL=1, V_SYNC_POL=1 and a 4/1/2/1 × 3/1/1/1 tiny mode -> sync pulses active-high at the computed positions; frame period 8×6 = 48 cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Free-running horizontal/vertical counters on vga_pix_clk produce the pixel
// coordinates, display enable, sync pulses and a once-per-frame strobe. All
// outputs are registered from the next-state counter values, so every output
// describes the same pixel in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build a completed-frame
// counter on frame_cnt. Without it, frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int H_VISIBLE_AREA  = 640,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC_PULSE    = 96,
  parameter int H_BACK_PORCH    = 48,
  parameter int V_VISIBLE_AREA  = 480,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC_PULSE    = 2,
  parameter int V_BACK_PORCH    = 33,
  parameter int H_SYNC_POL      = 0,
  parameter int V_SYNC_POL      = 0,
  parameter int FRAME_CNT_WIDTH = 16,
  localparam int H_WHOLE_LINE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE_LINE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int H_ADDR_WIDTH = $clog2(H_WHOLE_LINE),
  localparam int V_ADDR_WIDTH = $clog2(V_WHOLE_LINE)
) (
  input  logic                       vga_pix_clk,
  input  logic                       rst,
  output logic [H_ADDR_WIDTH-1:0]    sx,
  output logic [V_ADDR_WIDTH-1:0]    sy,
  output logic                       display_enabled,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       frame_stb,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

  // Counter-width constants so every comparison is unsigned at counter width.
  localparam logic [H_ADDR_WIDTH-1:0] H_ONE        = H_ADDR_WIDTH'(1);
  localparam logic [V_ADDR_WIDTH-1:0] V_ONE        = V_ADDR_WIDTH'(1);
  localparam logic [H_ADDR_WIDTH-1:0] H_MAX        = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_MAX        = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);
  localparam logic [H_ADDR_WIDTH-1:0] H_VIS        = H_ADDR_WIDTH'(H_VISIBLE_AREA);
  localparam logic [V_ADDR_WIDTH-1:0] V_VIS        = V_ADDR_WIDTH'(V_VISIBLE_AREA);
  localparam logic [H_ADDR_WIDTH-1:0] H_SYNC_START = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [H_ADDR_WIDTH-1:0] H_SYNC_END   = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [V_ADDR_WIDTH-1:0] V_SYNC_START = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [V_ADDR_WIDTH-1:0] V_SYNC_END   = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic                    H_ACTIVE     = (H_SYNC_POL != 0);
  localparam logic                    V_ACTIVE     = (V_SYNC_POL != 0);

  logic [H_ADDR_WIDTH-1:0] sx_next;
  logic [V_ADDR_WIDTH-1:0] sy_next;
  logic                    display_enabled_next;
  logic                    hsync_next;
  logic                    vsync_next;
  logic                    frame_stb_next;

  // Next raster position: step along the line, wrap to the next line, wrap the frame.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sx_next = sx + H_ONE;
    sy_next = sy;
    if (sx == H_MAX) begin
      sx_next = '0;
      sy_next = (sy == V_MAX) ? '0 : sy + V_ONE;
    end
  end

  // Decode the next position so the registered outputs line up with sx/sy.
  always_comb begin
    display_enabled_next = (sx_next < H_VIS) && (sy_next < V_VIS);
    hsync_next = ((sx_next >= H_SYNC_START) && (sx_next < H_SYNC_END)) ? H_ACTIVE : ~H_ACTIVE;
    vsync_next = ((sy_next >= V_SYNC_START) && (sy_next < V_SYNC_END)) ? V_ACTIVE : ~V_ACTIVE;
    frame_stb_next = (sx_next == '0) && (sy_next == V_VIS);
  end

  // Raster counters and decoded outputs, all updated on the same edge.
  always_ff @(posedge vga_pix_clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
    if (!rst) begin
      sx              <= '0;
      sy              <= '0;
      display_enabled <= 1'b0;
      hsync           <= ~H_ACTIVE;
      vsync           <= ~V_ACTIVE;
      frame_stb       <= 1'b0;
    end else begin
      sx              <= sx_next;
      sy              <= sy_next;
      display_enabled <= display_enabled_next;
      hsync           <= hsync_next;
      vsync           <= vsync_next;
      frame_stb       <= frame_stb_next;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Completed-frame counter; steps on the edge that raises frame_stb and wraps freely.
  always_ff @(posedge vga_pix_clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_stb_next) begin
      frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
    end
  end
`else
  // Feature disabled: the port stays but carries a constant zero.
  assign frame_cnt = '0;
`endif

endmodule
